uart_rx_axis: RTL
=================

Name: uart_rx_axis

Overview:
Serial UART receiver that sits directly upstream of the UART/TCP mux and drives its byte-stream input (uart_in_*). It samples the asynchronous rx line as 8N1 frames, LSB first, at a fixed clocks-per-bit rate, and buffers the received bytes in a small FIFO. It presents them as an AXI4-Stream master. Framing and overflow errors are reported as sticky flags.

Parameters:
CLKS_PER_BIT, 434, clk cycles per UART bit (>=4); 434 = 50 MHz / 115200.
FIFO_DEPTH, 4, receive FIFO entries (power of 2, >=2).
DATA_WIDTH, 8, AXIS data width (fixed at 8).

Ports:
clk  in  1  system clock; single clock domain.
rst_n  in  1  synchronous, active-low reset.
uart_rx  in  1  asynchronous serial line; idle high.
m_axis_tdata  out  8  received byte (head of FIFO).
m_axis_tvalid  out  1  FIFO non-empty.
m_axis_tready  in  1  consumer ready.
m_axis_tlast  out  1  tied 0.
frame_err  out  1  sticky: stop bit sampled low.
overflow  out  1  sticky: byte dropped because FIFO full.
err_clear  in  1  clears both sticky flags.
rx_busy  out  1  high whenever FSM is not IDLE.

Behaviour:
- Reset (rst_n low at a clk edge): FSM=IDLE, bit/clock counters=0, FIFO empty (pointers and count=0), synchroniser flops=1.
- Outputs during and after reset: m_axis_tvalid=0, m_axis_tdata=0, frame_err=0, overflow=0, rx_busy=0.
- Reset mid-frame abandons the partial byte; nothing is pushed.
- uart_rx passes through a 2-flop synchroniser, reset value 1. All decisions use the synchronised value rx_s.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
  - IDLE: rx_s==0 -> START, clk counter=0.
  - START: count to CLKS_PER_BIT/2-1 (integer division), i.e. mid start bit.
    - rx_s==0 -> DATA, counter=0, bit index=0.
    - Otherwise it is a glitch -> IDLE, no error.
  - DATA: every CLKS_PER_BIT cycles, sample rx_s into shift[bit index] (LSB first). After the 8th sample -> STOP.
  - STOP: after CLKS_PER_BIT cycles, sample rx_s.
    - 1: push byte, go IDLE.
    - 0: set frame_err, discard byte, go WAIT_IDLE.
  - WAIT_IDLE: stay until rx_s==1, then IDLE. A break condition never produces bytes.
- Push timing: the byte appears at FIFO head and m_axis_tvalid rises on the cycle after the stop-bit sample cycle.
- FIFO rules:
  - Pop when m_axis_tvalid && m_axis_tready.
  - Push is accepted if count<FIFO_DEPTH, or if a pop happens in the same cycle (count unchanged).
  - Otherwise the push is dropped, overflow sets, and FIFO contents are unchanged.
- FIFO pointers wrap modulo FIFO_DEPTH. count is $clog2(FIFO_DEPTH)+1 bits wide.
- m_axis_tdata = mem[rd_ptr] whenever tvalid=1. tdata and tvalid hold stable while tvalid && !tready (AXIS rule).
- Sticky flags: err_clear clears frame_err and overflow on the next edge. A set event in the same cycle as err_clear wins (the flag stays 1).
- rx_busy = (state != IDLE).

Test Plan:
- CLKS_PER_BIT=8: send 0xA5 with tready=1 -> exactly one beat, tdata=0xA5, tvalid high 1 cycle; frame_err=0; rx_busy low again after the stop sample.
- CLKS_PER_BIT=8, tready=0: send 0x00, 0x04, 0xFF, 0x07 back-to-back, then tready=1 -> beats 0x00, 0x04, 0xFF, 0x07 in order; tdata held stable while stalled; overflow=0.
- FIFO_DEPTH=4, tready=0: send 5 bytes 0x11..0x15 -> overflow=1; draining yields 0x11..0x14 only. Then err_clear for 1 cycle -> overflow=0.
- Stop bit forced low on a 0x3C frame, line held low for 40 clks, then high -> frame_err=1, no beat emitted. A following good 0x5A is received normally.
- Low pulse of 2 clks (< half bit) on idle line -> FSM returns to IDLE, no beat, no error flags.
- rst_n asserted during DATA of byte 0x81, released, then 0x42 sent -> only 0x42 emitted; all outputs 0 during reset.

Source files
------------

// File: rtl/uart_rx_axis.sv
// 8N1 UART receiver: samples the rx line at a fixed clocks-per-bit rate, buffers bytes in a
// small FIFO and presents them as an AXI4-Stream master with sticky framing/overflow flags.
module uart_rx_axis #(
   parameter int CLKS_PER_BIT = 434,
   parameter int FIFO_DEPTH   = 4,
   parameter int DATA_WIDTH   = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  uart_rx,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast,
   output logic                  frame_err,
   output logic                  overflow,
   input  logic                  err_clear,
   output logic                  rx_busy
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int BW = $clog2(DATA_WIDTH);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] IDX_LAST  = BW'(DATA_WIDTH - 1);
   localparam logic [AW:0]   DEPTH_C   = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_START     = 3'd1,
      S_DATA      = 3'd2,
      S_STOP      = 3'd3,
      S_WAIT_IDLE = 3'd4
   } state_t;

   state_t                state_q, state_d;
   logic                  sync1_q, rx_s_q;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [BW-1:0]         idx_q, idx_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic                  cnt_run, bit_tick, push_req, ferr_set;

   logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0]         rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [AW:0]           count_q, count_d;
   logic                  pop, push_ok, ovf_set;
   logic                  ferr_q, ferr_d, ovf_q, ovf_d;

   // Synchroniser resets to the idle level so reset never looks like a start bit.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_q <= 1'b1;
         rx_s_q  <= 1'b1;
      end else begin
         sync1_q <= uart_rx;
         rx_s_q  <= sync1_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:      if (!rx_s_q) state_d = S_START;
         S_START:     if (cnt_q == HALF_LAST) state_d = rx_s_q ? S_IDLE : S_DATA;
         S_DATA:      if (cnt_q == BIT_LAST && idx_q == IDX_LAST) state_d = S_STOP;
         S_STOP:      if (cnt_q == BIT_LAST) state_d = rx_s_q ? S_IDLE : S_WAIT_IDLE;
         S_WAIT_IDLE: if (rx_s_q) state_d = S_IDLE;
         default:     state_d = S_IDLE;
      endcase
   end

   // The bit counter clears exactly when it is not running, which covers every state exit.
   always_comb begin
      cnt_run  = 1'b0;
      bit_tick = 1'b0;
      push_req = 1'b0;
      ferr_set = 1'b0;
      case (state_q)
         S_START: cnt_run = (cnt_q != HALF_LAST);
         S_DATA: begin
            cnt_run  = (cnt_q != BIT_LAST);
            bit_tick = (cnt_q == BIT_LAST);
         end
         S_STOP: begin
            cnt_run  = (cnt_q != BIT_LAST);
            push_req = (cnt_q == BIT_LAST) && rx_s_q;
            ferr_set = (cnt_q == BIT_LAST) && !rx_s_q;
         end
         default: ;
      endcase
   end

   always_comb begin
      cnt_d   = cnt_run ? cnt_q + CW'(1) : '0;
      idx_d   = idx_q;
      shift_d = shift_q;
      if (state_q != S_DATA) begin
         idx_d = '0;
      end else if (bit_tick) begin
         idx_d          = idx_q + BW'(1);
         shift_d[idx_q] = rx_s_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
      end else begin
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
      end
   end

   // m_axis: a beat transfers on every edge with tvalid && tready; while tvalid && !tready
   // the head entry cannot move, so tdata/tvalid hold.
   assign m_axis_tvalid = (count_q != '0);
   assign m_axis_tdata  = m_axis_tvalid ? mem_q[rd_ptr_q] : '0;
   assign m_axis_tlast  = 1'b0;
   assign pop           = m_axis_tvalid && m_axis_tready;
   assign push_ok       = push_req && ((count_q != DEPTH_C) || pop);
   assign ovf_set       = push_req && !push_ok;

   always_comb begin
      rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
      wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
      case ({push_ok, pop})
         2'b10:   count_d = count_q + (AW + 1)'(1);
         2'b01:   count_d = count_q - (AW + 1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_n && push_ok) mem_q[wr_ptr_q] <= shift_q;
   end

   // A set event in the same cycle as err_clear keeps the flag high.
   assign ferr_d = ferr_set || (ferr_q && !err_clear);
   assign ovf_d  = ovf_set || (ovf_q && !err_clear);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         ferr_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         ferr_q   <= ferr_d;
         ovf_q    <= ovf_d;
      end
   end

   assign frame_err = ferr_q;
   assign overflow  = ovf_q;
   assign rx_busy   = (state_q != S_IDLE);

endmodule
